// File: rtl/iram_loader.sv
// Instruction-RAM loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive RAM addresses and can re-read them to confirm the running checksum.
module iram_loader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH         = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH:0]   num_words,
  input  logic                     verify,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     mem_wEn,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_dataIn,
  input  logic [DATA_WIDTH-1:0]    mem_dataOut,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [DATA_WIDTH-1:0]    checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, VLAST, CHECK, DONE} state_t;

  localparam logic [ADDRESS_WIDTH:0] DEPTH_C = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] ONE_C   = (ADDRESS_WIDTH+1)'(1);

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH:0]   count_reg;
  logic                     verify_reg;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [1:0]               byte_idx_reg;
  logic [DATA_WIDTH-1:0]    word_reg;
  logic [DATA_WIDTH-1:0]    acc_reg;

  logic                  take;
  logic                  last_addr;
  logic                  num_ok;
  logic [DATA_WIDTH-1:0] full_word;

  assign take      = byte_valid && byte_ready;
  assign last_addr = ({1'b0, addr_reg} == (count_reg - ONE_C));
  assign num_ok    = (num_words != '0) && (num_words <= DEPTH_C);
  // The 4th byte completes the word in the same cycle it is accepted.
  assign full_word = {byte_data, word_reg[DATA_WIDTH-9:0]};
  assign mem_addr  = addr_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = num_ok ? LOAD : DONE;
      LOAD:    if (take && byte_idx_reg == 2'd3) state_next = WRITE;
      WRITE:   begin
        if (last_addr) state_next = verify_reg ? VERIFY : DONE;
        else           state_next = LOAD;
      end
      VERIFY:  if (last_addr) state_next = VLAST;
      VLAST:   state_next = CHECK;
      CHECK:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake/strobe outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready   <= 1'b0;
      mem_wEn      <= 1'b0;
      mem_dataIn   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      checksum     <= '0;
      count_reg    <= '0;
      verify_reg   <= 1'b0;
      addr_reg     <= '0;
      byte_idx_reg <= '0;
      word_reg     <= '0;
      acc_reg      <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      byte_ready <= (state_next == LOAD);
      mem_wEn    <= (state_next == WRITE);
      done       <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              error <= 1'b0;
            end else if (!num_ok) begin
              error <= 1'b1;
            end else begin
              count_reg    <= num_words;
              verify_reg   <= verify;
              addr_reg     <= '0;
              byte_idx_reg <= '0;
              checksum     <= '0;
              acc_reg      <= '0;
              error        <= 1'b0;
            end
          end
        end
        LOAD: begin
          if (take) begin
            word_reg[{byte_idx_reg, 3'b000} +: 8] <= byte_data;
            byte_idx_reg <= byte_idx_reg + 2'd1;
            if (byte_idx_reg == 2'd3) begin
              mem_dataIn <= full_word;
              checksum   <= checksum + full_word;
            end
          end
        end
        WRITE: begin
          if (last_addr) addr_reg <= '0;
          else           addr_reg <= addr_reg + 1'b1;
        end
        VERIFY: begin
          // Read data lags the address by one cycle, so the first VERIFY cycle has nothing yet.
          if (addr_reg != '0) acc_reg <= acc_reg + mem_dataOut;
          if (!last_addr)     addr_reg <= addr_reg + 1'b1;
        end
        VLAST: acc_reg <= acc_reg + mem_dataOut;
        CHECK: error <= (acc_reg != checksum);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iram_loader.sv
// Directed/randomized bench for iram_loader: a RAM model plus a byte-level reference model
// that predicts written words, checksum, error and done timing.
module tb_iram_loader;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          verify = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, mem_wEn, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn, mem_dataOut, checksum;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ram [DEPTH];
  logic          corrupt_en = 1'b0;
  logic [7:0]    bytes_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            cyc = 0;
  int            last_wr_cyc = 0;
  int            done_cyc = 0;

  iram_loader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words), .verify(verify),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_wEn(mem_wEn), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // RAM: 1-cycle read latency, read data only refreshed when not writing.
  always @(posedge clk) begin
    if (mem_wEn === 1'b1)
      ram[mem_addr] <= (corrupt_en && mem_addr == 1) ? 32'h08070604 : mem_dataIn;
    else
      mem_dataOut <= ram[mem_addr];
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_wEn === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_dataIn);
      last_wr_cyc <= cyc;
    end
    if (done === 1'b1) done_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int w);
    return {bytes_q[4*w+3], bytes_q[4*w+2], bytes_q[4*w+1], bytes_q[4*w]};
  endfunction

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s = '0;
    for (int w = 0; w < n; w++) s = s + model_word(w);
    return s;
  endfunction

  task automatic fill_random(input int n);
    bytes_q.delete();
    for (int k = 0; k < 4*n; k++) bytes_q.push_back(8'($urandom));
  endtask

  task automatic fill_seq();
    bytes_q.delete();
    for (int k = 1; k <= 8; k++) bytes_q.push_back(8'(k));
  endtask

  task automatic feed(input int nbytes, input int gap);
    int i = 0;
    int budget = nbytes*30 + 100;
    while (i < nbytes && budget > 0) begin
      @(negedge clk);
      if ($urandom_range(0, 99) >= gap) begin
        byte_valid = 1'b1;
        byte_data  = bytes_q[i];
        if (byte_ready === 1'b1) i++;
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
      budget--;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    chk("feed_bytes", i, nbytes);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 1);
  endtask

  task automatic run_load(input int n, input bit ver, input int gap, input bit exp_err);
    int mism = 0;
    int ram_mism = 0;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = (AW+1)'(n); verify = ver;
    @(negedge clk);
    start = 1'b0;
    feed(4*n, gap);
    wait_done(n + 40);
    chk("error_at_done", error, exp_err);
    chk("checksum_at_done", checksum, model_sum(n));
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("write_count", wr_addr_q.size(), n);
    for (int w = 0; w < n && w < wr_addr_q.size(); w++)
      if (wr_addr_q[w] !== AW'(w) || wr_data_q[w] !== model_word(w)) mism++;
    chk("write_mismatches", mism, 0);
    chk("done_latency", done_cyc - last_wr_cyc, ver ? n + 3 : 1);
    if (!corrupt_en) begin
      for (int w = 0; w < n; w++) if (ram[w] !== model_word(w)) ram_mism++;
      chk("ram_readback", ram_mism, 0);
    end
    $display("load n=%0d verify=%0d gap=%0d checksum=%08h error=%0d", n, ver, gap, checksum, error);
  endtask

  task automatic bad_start(input int n, input bit exp_err, input string tag);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = (AW+1)'(n); verify = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, exp_err);
    @(negedge clk);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nowrite"}, wr_addr_q.size(), 0);
    $display("start n=%0d done error=%0d", n, error);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_mem_wEn", mem_wEn, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_dataIn", mem_dataIn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b0;

    // Basic load with the reference byte pattern
    fill_seq();
    run_load(2, 1'b0, 0, 1'b0);
    chk("basic_checksum", checksum, 32'h0C0A0806);
    chk("basic_word0", ram[0], 32'h04030201);
    chk("basic_word1", ram[1], 32'h08070605);

    // Verify pass, then verify fail with a corrupted RAM word
    run_load(2, 1'b1, 0, 1'b0);
    corrupt_en = 1'b1;
    run_load(2, 1'b1, 0, 1'b1);
    corrupt_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("error_sticky", error, 1);
    bad_start(0, 1'b0, "nw0");

    // Bytes offered in IDLE must not be consumed
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      chk("idle_not_ready", byte_ready, 0);
    end
    byte_valid = 1'b0;
    run_load(2, 1'b0, 40, 1'b0);
    chk("bp_checksum", checksum, 32'h0C0A0806);

    fill_random(5);
    run_load(5, 1'b1, 30, 1'b0);
    fill_random(3);
    run_load(3, 1'b0, 50, 1'b0);

    bad_start(4097, 1'b1, "nw4097");
    fill_random(DEPTH);
    run_load(DEPTH, 1'b0, 0, 1'b0);
    chk("full_last_addr", wr_addr_q.size() > 0 ? 32'(wr_addr_q[wr_addr_q.size()-1]) : 32'hFFFF_FFFF, 32'hFFF);

    // Reset after five bytes: one word written, partial word discarded
    fill_random(2);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1; num_words = 13'd2; verify = 1'b0;
    @(negedge clk);
    start = 1'b0;
    feed(5, 0);
    chk("pre_reset_writes", wr_addr_q.size(), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_byte_ready", byte_ready, 0);
    chk("mid_rst_mem_wEn", mem_wEn, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_checksum", checksum, 0);
    chk("mid_rst_error", error, 0);
    reset = 1'b0;
    fill_random(1);
    run_load(1, 1'b0, 20, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
